plab4_net_router_output_terminal_ctrl_tp: RTL and testbench

Timing-channel-protected output control for a router's terminal (ejection) port. It arbitrates among the west, terminal and east input units that request the terminal output, and grants only packets whose security domain owns the current time slot. It also generates the `domain0`/`domain1` slot indicators that the input terminal controls consume. Domains alternate in fixed-length slots with a guard window at the end of each slot, so one domain's traffic cannot change when the other domain's packets are serviced.

---
 rtl/plab4_net_router_output_terminal_ctrl_tp.sv | 110 +++++++++++
 tb/tb_plab4_net_router_output_terminal_ctrl_tp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_output_terminal_ctrl_tp.sv
// Terminal-port output control with time-slot domain isolation: round-robin
// grant among west/terminal/east, restricted to the domain owning the slot.
module plab4_net_router_output_terminal_ctrl_tp #(
  parameter int p_slot_len = 4,
  parameter int p_guard    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reqs,
  input  logic [2:0] req_domain,
  input  logic       out_rdy,
  output logic [2:0] grants,
  output logic       out_val,
  output logic [1:0] sel,
  output logic       domain0,
  output logic       domain1
);

  localparam int CW = (p_slot_len > 2) ? $clog2(p_slot_len) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(p_slot_len - 1);
  localparam int GUARD_START = p_slot_len - p_guard;

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic          cur_dom_q, cur_dom_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;

  logic          guard_s;
  logic [2:0]    elig_s;
  logic [2:0]    grants_s;
  logic [1:0]    sel_s;
  logic [1:0]    start_s;

  // Slot timing runs free of traffic: counter wraps and hands the slot over.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    cur_dom_d  = cur_dom_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      cur_dom_d  = ~cur_dom_q;
    end else begin
      slot_cnt_d = slot_cnt_q + CW'(1);
    end
  end

  // Only same-domain requests outside the guard window may compete.
  always_comb begin
    guard_s = (int'(slot_cnt_q) >= GUARD_START);
    for (int i = 0; i < 3; i++) begin
      elig_s[i] = reqs[i] & (req_domain[i] == cur_dom_q) & out_rdy & ~guard_s;
    end
  end

  // Priority start position decoded from the one-hot pointer.
  always_comb begin
    case (rr_ptr_q)
      3'b001:  start_s = 2'd0;
      3'b010:  start_s = 2'd1;
      3'b100:  start_s = 2'd2;
      default: start_s = 2'd0;
    endcase
  end

  // Round-robin search starting at the pointer, wrapping 2 -> 0.
  always_comb begin
    logic found;
    int   idx;
    grants_s = 3'b000;
    sel_s    = 2'd0;
    found    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(start_s) + k) % 3;
      if (!found && elig_s[idx]) begin
        grants_s[idx] = 1'b1;
        sel_s         = 2'(idx);
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Pointer moves just past the winner; holds when nobody is granted.
  always_comb begin
    if (|grants_s) begin
      rr_ptr_d = {grants_s[1:0], grants_s[2]};
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q <= '0;
      cur_dom_q  <= 1'b0;
      rr_ptr_q   <= 3'b001;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      cur_dom_q  <= cur_dom_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grants  = grants_s;
  assign out_val = |grants_s;
  assign sel     = sel_s;
  assign domain0 = ~cur_dom_q;
  assign domain1 = cur_dom_q;

endmodule

// File: tb/tb_plab4_net_router_output_terminal_ctrl_tp.sv
// Self-checking bench: directed slot/arbitration scenarios plus randomized
// traffic against a cycle-count based reference model.
module tb_plab4_net_router_output_terminal_ctrl_tp;

  localparam int L = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] req_domain;
  logic       out_rdy;
  logic [2:0] grants;
  logic       out_val;
  logic [1:0] sel;
  logic       domain0;
  logic       domain1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: cycles since reset and index of highest-priority input.
  int m_t   = 0;
  int m_ptr = 0;

  plab4_net_router_output_terminal_ctrl_tp #(.p_slot_len(L), .p_guard(G)) dut (
    .clk(clk), .reset(reset), .reqs(reqs), .req_domain(req_domain),
    .out_rdy(out_rdy), .grants(grants), .out_val(out_val), .sel(sel),
    .domain0(domain0), .domain1(domain1)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(input logic [2:0] r, input logic [2:0] d, input logic rdy);
    int dom;
    if (!rdy || (m_t % L) >= (L - G)) return -1;
    dom = (m_t / L) % 2;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (r[i] && (int'(d[i]) == dom)) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic [2:0] r, input logic [2:0] d, input logic rdy);
    reqs = r; req_domain = d; out_rdy = rdy;
    #1;
  endtask

  // Advance one clock, keeping the model in step with the applied inputs.
  task automatic tick();
    int g;
    g = model_grant(reqs, req_domain, out_rdy);
    if (reset) begin
      m_t = 0; m_ptr = 0;
    end else begin
      if (g >= 0) m_ptr = (g + 1) % 3;
      m_t = m_t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0);
    tick();
    n_cmp++;
    if (domain0 !== 1'b1 || domain1 !== 1'b0 || grants !== 3'b000 || out_val !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got d0=%b d1=%b g=%b v=%b sel=%0d, want 1 0 000 0 0",
               domain0, domain1, grants, out_val, sel);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      logic exp_d1;
      exp_d1 = (c >= 4 && c <= 7);
      #1;
      n_cmp++;
      if (domain1 !== exp_d1 || domain0 !== ~exp_d1 || grants !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_slots c%0d: got d0=%b d1=%b g=%b, want d0=%b d1=%b g=000",
                 c, domain0, domain1, grants, ~exp_d1, exp_d1);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [0:7];
    logic [1:0] exp_s [0:7];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(3'b111, 3'b000, 1'b1);
      n_cmp++;
      if (grants !== exp_g[c] || sel !== exp_s[c] || out_val !== (|exp_g[c])) begin
        n_fail++;
        $display("FAIL round_robin c%0d: got g=%b sel=%0d v=%b, want g=%b sel=%0d",
                 c, grants, sel, out_val, exp_g[c], exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_wrong_domain();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [2:0] eg;
      eg = (c == 4) ? 3'b001 : 3'b000;
      drive(3'b001, 3'b001, 1'b1);
      n_cmp++;
      if (grants !== eg || out_val !== (c == 4)) begin
        n_fail++;
        $display("FAIL wrong_domain c%0d: got g=%b v=%b, want g=%b", c, grants, out_val, eg);
      end
      tick();
    end
  endtask

  task automatic test_out_rdy();
    do_reset();
    drive(3'b110, 3'b000, 1'b0);
    n_cmp++;
    if (grants !== 3'b000) begin
      n_fail++;
      $display("FAIL rdy_low_grant: got %b want 000", grants);
    end
    tick();
    n_cmp++;
    if (dut.rr_ptr_q !== 3'b001) begin
      n_fail++;
      $display("FAIL rdy_low_ptr: got %b want 001", dut.rr_ptr_q);
    end
    drive(3'b110, 3'b000, 1'b1);
    n_cmp++;
    if (grants !== 3'b010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL rdy_high_grant: got g=%b sel=%0d want 010 1", grants, sel);
    end
    tick();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    drive(3'b001, 3'b000, 1'b1);
    tick();
    drive(3'b100, 3'b000, 1'b1);
    n_cmp++;
    if (grants !== 3'b100) begin
      n_fail++;
      $display("FAIL wrap_east: got %b want 100", grants);
    end
    tick();
    drive(3'b101, 3'b000, 1'b1);
    n_cmp++;
    if (grants !== 3'b001 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_west: got g=%b sel=%0d want 001 0", grants, sel);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(3'b000, 3'b000, 1'b1);
      tick();
    end
    reset = 1'b1;
    drive(3'b100, 3'b100, 1'b1);
    tick();
    reset = 1'b0;
    n_cmp++;
    if (domain0 !== 1'b1 || dut.slot_cnt_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got d0=%b cnt=%0d want 1 0", domain0, dut.slot_cnt_q);
    end
    for (int c = 0; c < 5; c++) begin
      logic [2:0] eg;
      eg = (c == 4) ? 3'b100 : 3'b000;
      drive(3'b100, 3'b100, 1'b1);
      n_cmp++;
      if (grants !== eg) begin
        n_fail++;
        $display("FAIL reset_mid_grant c%0d: got %b want %b", c, grants, eg);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [2:0] eg;
      logic [1:0] es;
      logic ed1;
      reset = ($urandom_range(0, 49) == 0);
      drive(3'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
      g   = model_grant(reqs, req_domain, out_rdy);
      eg  = (g >= 0) ? (3'b001 << g) : 3'b000;
      es  = (g >= 0) ? 2'(g) : 2'd0;
      ed1 = ((m_t / L) % 2) == 1;
      n_cmp++;
      if (grants !== eg || sel !== es || out_val !== (g >= 0) || domain1 !== ed1 || domain0 !== ~ed1) begin
        n_fail++;
        $display("FAIL random c%0d: got g=%b sel=%0d v=%b d1=%b, want g=%b sel=%0d d1=%b",
                 c, grants, sel, out_val, domain1, eg, es, ed1);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    reqs = 3'b000; req_domain = 3'b000; out_rdy = 1'b0;
    #2;
    test_reset();
    test_round_robin();
    test_wrong_domain();
    test_out_rdy();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
